// File: rtl/train_seq_ctrl_pkg.sv
// Shared constants, FSM state encoding and the constant slot-to-parameter table
// for the training sequencer (default 2-3-2 network, 32-bit fixed point).
package train_seq_ctrl_pkg;

   localparam int N  = 32;
   localparam int WT = 12;
   localparam int ND = 5;
   localparam int NP = WT + ND;
   localparam int BW = 8;
   localparam int SW = $clog2(NP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      WBACK = 2'd2,
      FIN   = 2'd3
   } state_t;

   typedef struct packed {
      logic       is_bias;
      logic [3:0] idx;
   } slot_map_t;

   // Per node: its weights in order, then its bias.
   function automatic slot_map_t slot_map(input int s);
      slot_map_t m;
      case (s)
         0:       m = '{is_bias: 1'b0, idx: 4'd0};
         1:       m = '{is_bias: 1'b0, idx: 4'd1};
         2:       m = '{is_bias: 1'b1, idx: 4'd0};
         3:       m = '{is_bias: 1'b0, idx: 4'd2};
         4:       m = '{is_bias: 1'b0, idx: 4'd3};
         5:       m = '{is_bias: 1'b1, idx: 4'd1};
         6:       m = '{is_bias: 1'b0, idx: 4'd4};
         7:       m = '{is_bias: 1'b0, idx: 4'd5};
         8:       m = '{is_bias: 1'b1, idx: 4'd2};
         9:       m = '{is_bias: 1'b0, idx: 4'd6};
         10:      m = '{is_bias: 1'b0, idx: 4'd7};
         11:      m = '{is_bias: 1'b0, idx: 4'd8};
         12:      m = '{is_bias: 1'b1, idx: 4'd3};
         13:      m = '{is_bias: 1'b0, idx: 4'd9};
         14:      m = '{is_bias: 1'b0, idx: 4'd10};
         15:      m = '{is_bias: 1'b0, idx: 4'd11};
         16:      m = '{is_bias: 1'b1, idx: 4'd4};
         default: m = '{is_bias: 1'b0, idx: 4'd0};
      endcase
      return m;
   endfunction

endpackage

// File: rtl/train_seq_ctrl_param_bank.sv
// Parameter register file: live copy drives wall/ball, shadow copy collects the
// write-back sweep and is committed in one edge so backprop inputs stay stable.
module train_seq_ctrl_param_bank
   import train_seq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_init_we,
   input  logic [SW-1:0]   i_init_addr,
   input  logic [N-1:0]    i_init_data,
   input  logic            i_cap_en,
   input  logic [SW-1:0]   i_cap_addr,
   input  logic [N-1:0]    i_cap_data,
   input  logic            i_commit,
   output logic [N*WT-1:0] o_wall,
   output logic [N*ND-1:0] o_ball
);

   for (genvar gi = 0; gi < NP; gi++) begin : g_slot
      localparam slot_map_t M       = slot_map(gi);
      localparam bit        IS_BIAS = M.is_bias;
      localparam int        IDX     = int'(M.idx);

      logic [N-1:0] r_live;
      logic [N-1:0] r_shadow;
      logic         w_init_hit;
      logic         w_cap_hit;

      assign w_init_hit = i_init_we && (i_init_addr == SW'(gi));
      assign w_cap_hit  = i_cap_en && (i_cap_addr == SW'(gi));

      // The final capture and the commit share an edge, so the bus value
      // bypasses the shadow for that slot.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_live   <= '0;
            r_shadow <= '0;
         end else if (w_init_hit) begin
            r_live   <= i_init_data;
            r_shadow <= i_init_data;
         end else begin
            if (w_cap_hit)
               r_shadow <= i_cap_data;
            if (i_commit)
               r_live <= w_cap_hit ? i_cap_data : r_shadow;
         end
      end

      if (IS_BIAS) begin : g_bias
         assign o_ball[IDX*N +: N] = r_live;
      end else begin : g_weight
         assign o_wall[IDX*N +: N] = r_live;
      end
   end

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-step sequencer: accumulate strobes per sample, then a one-hot
// write-back sweep capturing bus[N-1:0]. Optional AUTO_EPOCH_EN loops epochs.
module train_seq_ctrl
   import train_seq_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [BW-1:0]   batch_len,
   input  logic            sample_valid,
   output logic            sample_ready,
   input  logic            init_we,
   input  logic [SW-1:0]   init_addr,
   input  logic [N-1:0]    init_data,
   output logic [NP-1:0]   we,
   output logic            dtb,
   inout  wire  [2*N-1:0]  bus,
   output logic [N*WT-1:0] wall,
   output logic [N*ND-1:0] ball,
   output logic            busy,
   output logic            done
`ifdef AUTO_EPOCH_EN
   ,
   input  logic [15:0]     epochs,
   output logic [15:0]     epoch_cnt
`endif
);

   localparam logic [NP-1:0] MSB_ONEHOT = {1'b1, {(NP-1){1'b0}}};

   state_t          r_state;
   state_t          w_state_next;
   logic [BW-1:0]   r_cnt;
   logic [BW-1:0]   r_len;
   logic [SW-1:0]   r_slot;
   logic            w_last_slot;
   logic            w_last_sample;
   logic            w_unused_bus;
`ifdef AUTO_EPOCH_EN
   logic [15:0]     r_epochs;
   logic [15:0]     r_epoch_cnt;
   assign epoch_cnt = r_epoch_cnt;
`endif

   assign w_last_slot   = (r_slot == SW'(NP-1));
   assign w_last_sample = (r_cnt == r_len - BW'(1));
   assign busy          = (r_state != IDLE);
   assign w_unused_bus  = ^bus[2*N-1:N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      sample_ready = 1'b0;
      we           = '0;
      dtb          = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start)
               w_state_next = ACCUM;
         end
         ACCUM: begin
            sample_ready = 1'b1;
            if (sample_valid) begin
               we = '1;
               if (w_last_sample)
                  w_state_next = WBACK;
            end
         end
         WBACK: begin
            dtb = 1'b1;
            we  = MSB_ONEHOT >> r_slot;
            if (w_last_slot)
               w_state_next = FIN;
         end
         FIN: begin
`ifdef AUTO_EPOCH_EN
            if (r_epoch_cnt + 16'd1 == r_epochs) begin
               done         = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_state_next = ACCUM;
            end
`else
            done         = 1'b1;
            w_state_next = IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_len  <= '0;
         r_slot <= '0;
`ifdef AUTO_EPOCH_EN
         r_epochs    <= '0;
         r_epoch_cnt <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len  <= (batch_len == '0) ? BW'(1) : batch_len;
                  r_cnt  <= '0;
                  r_slot <= '0;
`ifdef AUTO_EPOCH_EN
                  r_epochs    <= (epochs == '0) ? 16'd1 : epochs;
                  r_epoch_cnt <= '0;
`endif
               end
            end
            ACCUM: begin
               if (sample_valid)
                  r_cnt <= w_last_sample ? '0 : r_cnt + BW'(1);
            end
            WBACK: begin
               r_slot <= w_last_slot ? '0 : r_slot + SW'(1);
            end
            FIN: begin
`ifdef AUTO_EPOCH_EN
               r_epoch_cnt <= r_epoch_cnt + 16'd1;
`endif
            end
         endcase
      end
   end

   train_seq_ctrl_param_bank u_bank (
      .clk         (clk),
      .rst         (rst),
      .i_init_we   (init_we && (r_state == IDLE)),
      .i_init_addr (init_addr),
      .i_init_data (init_data),
      .i_cap_en    (r_state == WBACK),
      .i_cap_addr  (r_slot),
      .i_cap_data  (bus[N-1:0]),
      .i_commit    ((r_state == WBACK) && w_last_slot),
      .o_wall      (wall),
      .o_ball      (ball)
   );

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Self-checking bench for train_seq_ctrl: directed phases with randomized data,
// checked against a slot/parameter model built from the network layer shape.
module tb_train_seq_ctrl;

   localparam int N  = 32;
   localparam int WT = 12;
   localparam int ND = 5;
   localparam int NP = 17;
   localparam int BW = 8;
   localparam logic [NP-1:0] ALL1 = '1;
   localparam logic [NP-1:0] TOP  = 17'h10000;

   logic            clk = 1'b0;
   logic            rst, start, sample_valid, init_we, bus_en;
   logic [BW-1:0]   batch_len;
   logic [4:0]      init_addr;
   logic [N-1:0]    init_data;
   logic [2*N-1:0]  bus_drv;
   wire  [2*N-1:0]  bus;
   logic            sample_ready, dtb, busy, done;
   logic [NP-1:0]   we;
   logic [N*WT-1:0] wall;
   logic [N*ND-1:0] ball;
`ifdef AUTO_EPOCH_EN
   logic [15:0]     epochs, epoch_cnt;
`endif

   int vec_cnt  = 0;
   int miss_cnt = 0;
   logic [N-1:0] model  [NP];
   logic [N-1:0] shadow [NP];

   assign bus = bus_en ? bus_drv : 'z;
   always #5 clk = ~clk;

   train_seq_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .batch_len    (batch_len),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .init_we      (init_we),
      .init_addr    (init_addr),
      .init_data    (init_data),
      .we           (we),
      .dtb          (dtb),
      .bus          (bus),
      .wall         (wall),
      .ball         (ball),
      .busy         (busy),
      .done         (done)
`ifdef AUTO_EPOCH_EN
      ,
      .epochs       (epochs),
      .epoch_cnt    (epoch_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Node n (0..2 in the hidden layer, 3..4 in the output layer) owns its
   // fan-in weights followed by one bias, laid out consecutively in slots.
   function automatic int fanin(input int n);
      return (n < 3) ? 2 : 3;
   endfunction

   function automatic logic [N*WT-1:0] exp_wall();
      logic [N*WT-1:0] r = '0;
      int s = 0;
      int w = 0;
      for (int n = 0; n < ND; n++) begin
         for (int j = 0; j < fanin(n); j++) begin
            r[w*N +: N] = model[s];
            s++;
            w++;
         end
         s++;
      end
      return r;
   endfunction

   function automatic logic [N*ND-1:0] exp_ball();
      logic [N*ND-1:0] r = '0;
      int s = 0;
      for (int n = 0; n < ND; n++) begin
         s += fanin(n);
         r[n*N +: N] = model[s];
         s++;
      end
      return r;
   endfunction

   task automatic chk_params(input string tag);
      chk({tag, "_wall"}, wall, exp_wall());
      chk({tag, "_ball"}, ball, exp_ball());
   endtask

   // One start..done run. gap<0 gives random valid gaps; bus_mode 0 drives
   // 100+slot, otherwise random data. abort_at>=0 asserts rst at that sweep cycle.
   task automatic run_batch(input int len_in, input int gap, input int bus_mode,
                            input bit misc, input int abort_at, input int n_ep);
      int L = (len_in == 0) ? 1 : len_in;
      int acc, ac;
      bit v;
      start     = 1'b1;
      batch_len = BW'(len_in);
`ifdef AUTO_EPOCH_EN
      epochs    = 16'(n_ep);
`endif
      cyc();
      start = 1'b0;
      for (int e = 0; e < n_ep; e++) begin
         acc = 0;
         ac  = 0;
         while (acc < L) begin
            v = (gap < 0) ? 1'($urandom_range(0, 1)) : ((ac % (gap + 1)) == gap);
            sample_valid = v;
            if (misc && ac == 1) begin
               start     = 1'b1;
               batch_len = 8'd7;
               init_we   = 1'b1;
               init_addr = 5'd0;
               init_data = 32'hDEAD_BEEF;
            end
            #1;
            chk($sformatf("accum_ready[%0d]", ac), sample_ready, 1'b1);
            chk($sformatf("accum_we[%0d]", ac), we, v ? ALL1 : '0);
            chk($sformatf("accum_dtb[%0d]", ac), dtb, 1'b0);
            chk($sformatf("accum_done[%0d]", ac), done, 1'b0);
            if (v) acc++;
            ac++;
            cyc();
            start        = 1'b0;
            init_we      = 1'b0;
            sample_valid = 1'b0;
         end
         for (int k = 0; k < NP; k++) begin
            shadow[k]    = (bus_mode == 0) ? 32'(100 + k) : 32'($urandom);
            bus_drv      = {32'($urandom), shadow[k]};
            bus_en       = 1'b1;
            sample_valid = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("wb_we[%0d]", k), we, TOP >> k);
            chk($sformatf("wb_dtb[%0d]", k), dtb, 1'b1);
            chk($sformatf("wb_ready[%0d]", k), sample_ready, 1'b0);
            chk($sformatf("wb_done[%0d]", k), done, 1'b0);
            chk($sformatf("wb_busy[%0d]", k), busy, 1'b1);
            chk_params($sformatf("wb_hold[%0d]", k));
            if (k == abort_at) begin
               rst = 1'b1;
               #1;
               for (int s = 0; s < NP; s++) model[s] = '0;
               chk("abort_dtb", dtb, 1'b0);
               chk("abort_we", we, '0);
               chk("abort_busy", busy, 1'b0);
               chk_params("abort");
               sample_valid = 1'b0;
               bus_en       = 1'b0;
               cyc();
               rst = 1'b0;
               #1;
               chk("abort_idle_busy", busy, 1'b0);
               return;
            end
            cyc();
         end
         bus_en       = 1'b0;
         sample_valid = 1'b0;
         for (int s = 0; s < NP; s++) model[s] = shadow[s];
         #1;
         chk("fin_dtb", dtb, 1'b0);
         chk("fin_we", we, '0);
         chk("fin_done", done, (e == n_ep - 1));
         chk("fin_busy", busy, 1'b1);
`ifdef AUTO_EPOCH_EN
         chk($sformatf("fin_epoch[%0d]", e), epoch_cnt, 16'(e));
`endif
         chk_params("fin");
         cyc();
      end
      #1;
      chk("post_busy", busy, 1'b0);
      chk("post_done", done, 1'b0);
      chk_params("post");
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      sample_valid = 1'b0;
      init_we      = 1'b0;
      init_addr    = '0;
      init_data    = '0;
      batch_len    = '0;
      bus_en       = 1'b0;
      bus_drv      = '0;
`ifdef AUTO_EPOCH_EN
      epochs       = 16'd1;
`endif
      for (int s = 0; s < NP; s++) model[s] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_we", we, '0);
      chk("rst_dtb", dtb, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", sample_ready, 1'b0);
      chk_params("rst");
      rst = 1'b0;
      cyc();

      for (int s = 0; s < NP; s++) begin
         init_we   = 1'b1;
         init_addr = 5'(s);
         init_data = $urandom;
         model[s]  = init_data;
         cyc();
      end
      init_addr = 5'd0;  init_data = 32'h0010_0000; model[0] = init_data; cyc();
      init_addr = 5'd2;  init_data = 32'hFFF0_0000; model[2] = init_data; cyc();
      init_addr = 5'd20; init_data = 32'h1234_5678; cyc();
      init_we = 1'b0;
      #1;
      chk("init_w0", wall[31:0], 32'h0010_0000);
      chk("init_b0", ball[31:0], 32'hFFF0_0000);
      chk("init_busy", busy, 1'b0);
      chk_params("init");

      run_batch(3, 0, 0, 1'b0, -1, 1);
      chk("wb_w0", wall[31:0], 32'd100);
      chk("wb_w1", wall[63:32], 32'd101);
      chk("wb_b0", ball[31:0], 32'd102);
      chk("wb_w2", wall[95:64], 32'd103);
      chk("wb_b4", ball[159:128], 32'd116);

      run_batch(2, 4, 1, 1'b1, -1, 1);
      run_batch(3, 0, 1, 1'b0, 5, 1);
      run_batch(0, 0, 1, 1'b0, -1, 1);
      repeat (3) run_batch(int'($urandom_range(1, 6)), -1, 1, 1'b0, -1, 1);
`ifdef AUTO_EPOCH_EN
      run_batch(1, 0, 1, 1'b0, -1, 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/train_seq_ctrl.md
Name: train_seq_ctrl

Overview:
- Sequencer and parameter store for one training step around the backprop stage.
- Holds every weight and bias in registers and drives the packed weight vector to the forward and backprop stages.
- During a batch, issues one accumulate strobe per sample on we with dtb low.
- After the batch, runs a write-back sweep with dtb high. It walks a one-hot we from MSB to LSB and captures each updated parameter from bus.

Parameters:
- N, `n (32), total fixed-point width, taken from fixed_point.vh.
- WT, 12, number of weights.
- ND, 5, number of non-input nodes, which is also the number of biases.
- NP, WT+ND (17), parameter slots, which is also the we width.
- BW, 8, batch counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins a batch; ignored unless in IDLE.
- batch_len  in  BW  samples per batch; sampled on start; value 0 is treated as 1.
- sample_valid  in  1  backprop inputs (nx, yall, lt) for one sample are stable this cycle.
- sample_ready  out  1  high in ACCUM; transfer when sample_valid & sample_ready.
- init_we  in  1  writes init_data into slot init_addr; honoured only in IDLE.
- init_addr  in  $clog2(NP)  slot index.
- init_data  in  N  signed parameter value.
- we  out  NP  enables sent to backprop.
- dtb  out  1  0 = accumulate, 1 = bus write-back.
- bus  inout  2N  shared bus; this block never drives it and only samples bus[N-1:0].
- wall  out  N*WT  packed weights; weight w at bits [w*N +: N].
- ball  out  N*ND  packed biases; bias b at bits [b*N +: N].
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when write-back completes.

Behaviour:
- Slot map: slot s is driven by we[NP-1-s].
- Slot-to-parameter mapping per layer, in order:
  - node-0 weights, then node-0 bias, then node-1 weights, then node-1 bias, and so on.
  - For the default 2-3-2 net: slots 0,1 = w0,w1; slot 2 = b0; slots 3,4 = w2,w3; slot 5 = b1; ...; slot 16 = b4.
  - The mapping is a constant table.
- Reset (async, rst=1):
  - state IDLE.
  - All parameters 0.
  - we=0, dtb=0, done=0, sample_ready=0, batch counter 0.
- States: IDLE, ACCUM, WBACK, FIN.
- IDLE:
  - init writes land in 1 cycle; the wall/ball outputs update the next cycle.
  - start moves to ACCUM and latches batch_len as L.
- ACCUM:
  - sample_ready=1.
  - Each accepted sample drives we = all-ones and dtb=0 for exactly that cycle, then increments cnt.
  - When cnt reaches L-1 and a sample is accepted, the state goes to WBACK on the next edge.
  - Samples arriving in WBACK/FIN are not accepted (ready=0).
- WBACK:
  - dtb=1 for NP consecutive cycles.
  - Cycle k drives we = one-hot bit NP-1-k.
  - At the end of that cycle, bus[N-1:0] is captured into slot k.
  - Captured values become visible on wall/ball only after the sweep, at the WBACK to FIN edge. Values are shadowed so the backprop inputs stay stable during the sweep.
- FIN:
  - we=0, dtb=0 for 1 cycle.
  - The shadow is committed to wall/ball, done=1, then the state goes to IDLE.
- Latency: start to done = L accepted samples + NP + 1 cycles, with no sample gaps. That is 21 cycles for L=3 and NP=17 with back-to-back samples.
- Widths: the counter saturates to nothing, and L ≤ 2^BW-1 is guaranteed by the width. Captured values are stored unmodified as signed N-bit.
- Undriven bus (contains z/x during WBACK): the value is stored as sampled. This is a simulation-only hazard, and verification flags it.
- start during non-IDLE is ignored. init_we during non-IDLE is ignored.
- rst mid-sweep aborts:
  - All parameters, including the shadow, go to 0.
  - dtb drops asynchronously.

Optional Feature:
- AUTO_EPOCH_EN
- Defined:
  - Adds input epochs[15:0] (latched on start) and output epoch_cnt[15:0].
  - FIN returns to ACCUM instead of IDLE until epoch_cnt+1 == epochs.
  - done pulses only after the final epoch.
  - epoch_cnt increments each FIN and resets to 0 on start/rst.
  - epochs=0 is treated as 1.
- Undefined: single-epoch behaviour as above, with no extra ports.

Decomposition:
- Header constants go in fixed_point.vh: `n, `f, `i.
- New shared header train_pkg.vh:
  - State encodings IDLE=0, ACCUM=1, WBACK=2, FIN=3.
  - Slot-to-parameter mapping macro or function.
- One natural sub-module: param_bank, holding the NP-entry register file with the shadow copy, init write port, capture port and commit strobe.
- The FSM and counters stay in train_seq_ctrl.

Test Plan:
- Reset then init: write slot 0 = 32'h0010_0000 and slot 2 = 32'hFFF0_0000. Required: wall[31:0] = 0010_0000, ball[31:0] = FFF0_0000, busy=0.
- Accumulate strobes: start with batch_len=3, 3 back-to-back sample_valid. Required:
  - we = 17'h1FFFF with dtb=0 on exactly 3 cycles.
  - Then 17 cycles of dtb=1 with we = 17'h10000, 17'h08000, …, 17'h00001.
- Write-back capture: the bench drives bus = 64'(slot index + 100) during the sweep. Required:
  - wall/ball unchanged until FIN.
  - Then w0=100, w1=101, b0=102, w2=103, …, b4=116.
  - done pulses once, 21 cycles after start.
- Stall and ignore: batch_len=2 with valid gaps of 4 cycles. Required:
  - Strobes occur only on accepted cycles.
  - start and init_we issued mid-batch have no effect; L stays 2.
- Reset mid-WBACK: assert rst at sweep cycle 5. Required:
  - dtb=0 immediately; all params 0; state IDLE.
  - A following start with batch_len=0 runs as L=1.
- AUTO_EPOCH_EN (epochs=3, batch_len=1): three sweeps with epoch_cnt 0→1→2, a single done pulse at the end, busy high throughout.
